slow_clk_monitor: RTL



---
 rtl/slow_clk_monitor_pkg.sv | 15 +
 rtl/slow_clk_monitor_sync_edge_detect.sv | 39 +++
 rtl/slow_clk_monitor.sv | 113 +++++++++++
 3 files changed

// File: rtl/slow_clk_monitor_pkg.sv
// Shared types and default constants for the slow-clock monitor.
// Optional feature macro used by this block: SLOW_CLK_MONITOR_FALL_TICK_EN.
package slow_clk_monitor_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int PERIOD_W_DEF    = 16;
    localparam int TIMEOUT_DEF     = 65535;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        LOST       = 2'd2
    } state_e;

endpackage

// File: rtl/slow_clk_monitor_sync_edge_detect.sv
// Multi-flop synchronizer plus history flop; combinational rise/fall strobes.
// Falling-edge strobe is only built with SLOW_CLK_MONITOR_FALL_TICK_EN defined.
module sync_edge_detect
    import slow_clk_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_out;
        end
    end

    assign rise = sync_out & ~hist_q;

`ifdef SLOW_CLK_MONITOR_FALL_TICK_EN
    assign fall = ~sync_out & hist_q;
`else
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/slow_clk_monitor.sv
// Synchronizes a divided clock, emits one-cycle ticks, measures its period and flags loss.
// Define SLOW_CLK_MONITOR_FALL_TICK_EN to enable the registered falling-edge tick.
module slow_clk_monitor
    import slow_clk_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int PERIOD_W    = PERIOD_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                slow_clk,
    output logic                tick,
    output logic                fall_tick,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                lost
);

    localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);
    localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);

    logic rise;
    logic fall;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk     (clk),
        .reset   (reset),
        .async_in(slow_clk),
        .rise    (rise),
        .fall    (fall)
    );

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_d;
    logic                valid_d;
    logic                lost_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_FIRST;
            cnt_q        <= '0;
            tick         <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            lost         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tick         <= rise;
            period       <= period_d;
            period_valid <= valid_d;
            lost         <= lost_d;
        end
    end

    // A rise always restarts the count; the timeout is only checked when no rise is present.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period;
        valid_d  = period_valid;
        lost_d   = lost;
        case (state_q)
            WAIT_FIRST: begin
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    cnt_d    = CNT_ONE;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = LOST;
                    lost_d  = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LOST: begin
                // Interval spanning the outage is not a valid period, so nothing is captured.
                if (rise) begin
                    state_d = MEASURE;
                    lost_d  = 1'b0;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = WAIT_FIRST;
            end
        endcase
    end

`ifdef SLOW_CLK_MONITOR_FALL_TICK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fall_tick <= 1'b0;
        end else begin
            fall_tick <= fall;
        end
    end
`else
    assign fall_tick = fall;
`endif

endmodule
